dev_dpdm: RTL and testbench

Device-side DP/DM line interface. It is the far end of the host DP/DM block.
- Receive path: detects a host SYNC on the line, streams the payload bits to the device decoding pipeline, and detects EOP.
- Transmit path: sends device responses onto the line as SYNC, payload, SE0 EOP, then idle.
- The block is half-duplex. The receiver is blind while the transmitter drives the line.

---
 rtl/dev_dpdm_pkg.sv | 31 +++
 rtl/dev_dpdm_rx.sv | 119 +++++++++++
 rtl/dev_dpdm.sv | 181 ++++++++++++++++++
 tb/tb_dev_dpdm.sv | 266 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/dev_dpdm_pkg.sv
// dpdm_pkg: shared definitions for the device-side DP/DM line interface.
//   - line-symbol encodings as {dp, dm}
//   - SYNC pattern on D+ (MSB is sent first)
//   - RX / TX state enums
//   - default timing parameters and small symbol helpers
package dpdm_pkg;

  localparam logic [1:0] SYM_IDLE = 2'b10;
  localparam logic [1:0] SYM_SE0  = 2'b00;
  localparam logic [1:0] SYM_SE1  = 2'b11;

  localparam logic [7:0] SYNC_DP  = 8'b0101_0100;

  localparam int SE0_CYCLES_DEF = 2;
  localparam int TURNAROUND_DEF = 2;
  localparam int MAX_BITS_DEF   = 127;

  typedef enum logic [1:0] {R_SEEK, R_DATA, R_EOP} rx_state_t;
  typedef enum logic [2:0] {T_IDLE, T_WAIT, T_SYNC, T_DATA, T_SE0, T_J} tx_state_t;

  // D+ level of SYNC symbol number idx (0 = first on the wire).
  function automatic logic sync_dp_at(input logic [2:0] idx);
    return SYNC_DP[3'd7 - idx];
  endfunction

  // A data symbol has complementary lines.
  function automatic logic is_data_sym(input logic [1:0] sym);
    return sym[1] ^ sym[0];
  endfunction

endpackage

// File: rtl/dev_dpdm_rx.sv
// dev_dpdm_rx: receive half of the device DP/DM interface.
// Looks for the 8-symbol host SYNC, streams payload bits, and checks the EOP.
// Ports:
//   clk, rst_b          clock, async active-low reset
//   dp_i, dm_i          sampled line
//   hold_i              force the receiver to idle (transmitter owns the line)
//   bit_o, valid_o      payload bit and its strobe (one cycle after the symbol)
//   done_o, err_o       clean end-of-packet / error pulses
//   seek_idle_o         no SYNC in progress (safe point to start transmitting)
module dev_dpdm_rx
  import dpdm_pkg::*;
#(
  parameter int MAX_BITS = MAX_BITS_DEF
) (
  input  logic clk,
  input  logic rst_b,
  input  logic dp_i,
  input  logic dm_i,
  input  logic hold_i,
  output logic bit_o,
  output logic valid_o,
  output logic done_o,
  output logic err_o,
  output logic seek_idle_o
);

  localparam logic [6:0] MAX_CNT = 7'(MAX_BITS);

  rx_state_t  state_q;
  logic [2:0] sync_cnt_q;
  logic [6:0] bit_cnt_q;
  logic       bit_q;
  logic       valid_q;
  logic       done_q;
  logic       err_q;
  logic [1:0] line_sym;

  assign line_sym    = {dp_i, dm_i};
  assign seek_idle_o = (state_q == R_SEEK) && (sync_cnt_q == 3'd0);
  assign bit_o       = bit_q;
  assign valid_o     = valid_q;
  assign done_o      = done_q;
  assign err_o       = err_q;

  // Receive FSM with registered strobes; strobes default low every cycle.
  always_ff @(posedge clk or negedge rst_b) begin
    if (!rst_b) begin
      state_q    <= R_SEEK;
      sync_cnt_q <= 3'd0;
      bit_cnt_q  <= 7'd0;
      bit_q      <= 1'b0;
      valid_q    <= 1'b0;
      done_q     <= 1'b0;
      err_q      <= 1'b0;
    end else begin
      valid_q <= 1'b0;
      done_q  <= 1'b0;
      err_q   <= 1'b0;
      if (hold_i) begin
        state_q    <= R_SEEK;
        sync_cnt_q <= 3'd0;
      end else begin
        case (state_q)
          R_SEEK: begin
            // A mismatch simply restarts the count; the failing symbol is not
            // re-examined as a possible first SYNC symbol.
            if (line_sym == {sync_dp_at(sync_cnt_q), ~sync_dp_at(sync_cnt_q)}) begin
              if (sync_cnt_q == 3'd7) begin
                state_q    <= R_DATA;
                bit_cnt_q  <= 7'd0;
                sync_cnt_q <= 3'd0;
              end else begin
                sync_cnt_q <= sync_cnt_q + 3'd1;
              end
            end else begin
              sync_cnt_q <= 3'd0;
            end
          end
          R_DATA: begin
            if (is_data_sym(line_sym)) begin
              // bit_cnt never passes MAX_CNT, so it cannot wrap.
              if (bit_cnt_q == MAX_CNT) begin
                err_q   <= 1'b1;
                state_q <= R_SEEK;
              end else begin
                bit_q     <= dp_i;
                valid_q   <= 1'b1;
                bit_cnt_q <= bit_cnt_q + 7'd1;
              end
            end else if (line_sym == SYM_SE0) begin
              state_q <= R_EOP;
            end else begin
              err_q   <= 1'b1;
              state_q <= R_SEEK;
            end
          end
          R_EOP: begin
            case (line_sym)
              SYM_SE0:  state_q <= R_EOP;
              SYM_IDLE: begin
                done_q  <= 1'b1;
                state_q <= R_SEEK;
              end
              default: begin
                err_q   <= 1'b1;
                state_q <= R_SEEK;
              end
            endcase
          end
          default: begin
            state_q    <= R_SEEK;
            sync_cnt_q <= 3'd0;
          end
        endcase
      end
    end
  end

endmodule

// File: rtl/dev_dpdm.sv
// dev_dpdm: device-side DP/DM line interface (half duplex).
// Ports:
//   clk, rst_b                 clock, async active-low reset
//   dp_in, dm_in               sampled line
//   dp_out, dm_out, oe         driven line and drive enable (idle J when oe=0)
//   rx_bit, rx_valid           received payload stream
//   rx_done, rx_err            receive end / error pulses
//   tx_start, tx_len           send request and payload length (incl. stuffing)
//   tx_bit, tx_req             payload source handshake (bit taken when tx_req=1)
//   tx_busy, tx_done           transmit status and completion pulse
module dev_dpdm
  import dpdm_pkg::*;
#(
  parameter int SE0_CYCLES = SE0_CYCLES_DEF,
  parameter int TURNAROUND = TURNAROUND_DEF,
  parameter int MAX_BITS   = MAX_BITS_DEF
) (
  input  logic       clk,
  input  logic       rst_b,
  input  logic       dp_in,
  input  logic       dm_in,
  output logic       dp_out,
  output logic       dm_out,
  output logic       oe,
  output logic       rx_bit,
  output logic       rx_valid,
  output logic       rx_done,
  output logic       rx_err,
  input  logic       tx_start,
  input  logic [6:0] tx_len,
  input  logic       tx_bit,
  output logic       tx_req,
  output logic       tx_busy,
  output logic       tx_done
);

  localparam logic [6:0] TA_LAST  = 7'(TURNAROUND - 1);
  localparam logic [6:0] SE0_LAST = 7'(SE0_CYCLES - 1);

  tx_state_t  tx_state_q;
  logic [6:0] tx_cnt_q;
  logic [6:0] tx_len_q;
  logic       oe_q;
  logic       dp_q;
  logic       dm_q;
  logic       tx_req_q;
  logic       tx_busy_q;
  logic       tx_done_q;
  logic       rx_hold;
  logic       rx_seek_idle;
  logic       tx_accept;

  // The receiver is blind from acceptance until the line is released.
  assign rx_hold   = oe_q || (tx_state_q == T_WAIT);
  assign tx_accept = tx_start && (tx_state_q == T_IDLE) && rx_seek_idle;

  assign dp_out  = dp_q;
  assign dm_out  = dm_q;
  assign oe      = oe_q;
  assign tx_req  = tx_req_q;
  assign tx_busy = tx_busy_q;
  assign tx_done = tx_done_q;

  dev_dpdm_rx #(.MAX_BITS(MAX_BITS)) u_rx (
    .clk         (clk),
    .rst_b       (rst_b),
    .dp_i        (dp_in),
    .dm_i        (dm_in),
    .hold_i      (rx_hold),
    .bit_o       (rx_bit),
    .valid_o     (rx_valid),
    .done_o      (rx_done),
    .err_o       (rx_err),
    .seek_idle_o (rx_seek_idle)
  );

  // Transmit FSM; line outputs are loaded for the state being entered.
  always_ff @(posedge clk or negedge rst_b) begin
    if (!rst_b) begin
      tx_state_q <= T_IDLE;
      tx_cnt_q   <= 7'd0;
      tx_len_q   <= 7'd0;
      oe_q       <= 1'b0;
      dp_q       <= 1'b1;
      dm_q       <= 1'b0;
      tx_req_q   <= 1'b0;
      tx_busy_q  <= 1'b0;
      tx_done_q  <= 1'b0;
    end else begin
      tx_done_q <= 1'b0;
      case (tx_state_q)
        T_IDLE: begin
          if (tx_accept) begin
            tx_state_q <= T_WAIT;
            tx_cnt_q   <= 7'd0;
            tx_len_q   <= tx_len;
            tx_busy_q  <= 1'b1;
          end else begin
            tx_busy_q  <= 1'b0;
          end
        end
        T_WAIT: begin
          if (tx_cnt_q == TA_LAST) begin
            tx_state_q <= T_SYNC;
            tx_cnt_q   <= 7'd0;
            oe_q       <= 1'b1;
            dp_q       <= sync_dp_at(3'd0);
            dm_q       <= ~sync_dp_at(3'd0);
          end else begin
            tx_cnt_q   <= tx_cnt_q + 7'd1;
          end
        end
        T_SYNC: begin
          if (tx_cnt_q == 7'd7) begin
            tx_cnt_q <= 7'd0;
            if (tx_len_q == 7'd0) begin
              tx_state_q <= T_SE0;
              dp_q       <= 1'b0;
              dm_q       <= 1'b0;
              tx_req_q   <= 1'b0;
            end else begin
              tx_state_q <= T_DATA;
              dp_q       <= tx_bit;
              dm_q       <= ~tx_bit;
              tx_req_q   <= (tx_len_q > 7'd1);
            end
          end else begin
            tx_cnt_q <= tx_cnt_q + 7'd1;
            dp_q     <= sync_dp_at(tx_cnt_q[2:0] + 3'd1);
            dm_q     <= ~sync_dp_at(tx_cnt_q[2:0] + 3'd1);
            // First request rides on the last SYNC symbol.
            tx_req_q <= (tx_cnt_q == 7'd6) && (tx_len_q != 7'd0);
          end
        end
        T_DATA: begin
          if (tx_cnt_q == tx_len_q - 7'd1) begin
            tx_state_q <= T_SE0;
            tx_cnt_q   <= 7'd0;
            dp_q       <= 1'b0;
            dm_q       <= 1'b0;
            tx_req_q   <= 1'b0;
          end else begin
            tx_cnt_q <= tx_cnt_q + 7'd1;
            dp_q     <= tx_bit;
            dm_q     <= ~tx_bit;
            // Request only while another bit remains after the one now driven.
            tx_req_q <= ({1'b0, tx_cnt_q} + 8'd2) < {1'b0, tx_len_q};
          end
        end
        T_SE0: begin
          if (tx_cnt_q == SE0_LAST) begin
            tx_state_q <= T_J;
            tx_cnt_q   <= 7'd0;
            dp_q       <= 1'b1;
            dm_q       <= 1'b0;
          end else begin
            tx_cnt_q   <= tx_cnt_q + 7'd1;
          end
        end
        T_J: begin
          tx_state_q <= T_IDLE;
          oe_q       <= 1'b0;
          dp_q       <= 1'b1;
          dm_q       <= 1'b0;
          tx_busy_q  <= 1'b0;
          tx_done_q  <= 1'b1;
        end
        default: begin
          tx_state_q <= T_IDLE;
          tx_cnt_q   <= 7'd0;
          oe_q       <= 1'b0;
          dp_q       <= 1'b1;
          dm_q       <= 1'b0;
          tx_req_q   <= 1'b0;
          tx_busy_q  <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_dev_dpdm.sv
// tb_dev_dpdm: self-checking bench for dev_dpdm.
// Expected behaviour is derived from packet descriptions: each line symbol is
// tagged with the response it should provoke one clock later (RX), and the TX
// waveform is computed from the packet timeline arithmetic.
module tb_dev_dpdm;

  localparam int TA   = 2;
  localparam int SE0N = 2;

  logic       clk = 1'b0;
  logic       rst_b = 1'b0;
  logic       dp_in = 1'b1;
  logic       dm_in = 1'b0;
  logic       tx_start = 1'b0;
  logic [6:0] tx_len = 7'd0;
  logic       tx_bit = 1'b0;
  logic       dp_out, dm_out, oe, rx_bit, rx_valid, rx_done, rx_err;
  logic       tx_req, tx_busy, tx_done;

  int n_cmp = 0;
  int n_bad = 0;

  logic [7:0] sync_v = 8'b0101_0100;

  logic [1:0] sym_q[$];
  logic       ev_q[$], eb_q[$], ed_q[$], ee_q[$];

  dev_dpdm dut (
    .clk(clk), .rst_b(rst_b), .dp_in(dp_in), .dm_in(dm_in),
    .dp_out(dp_out), .dm_out(dm_out), .oe(oe),
    .rx_bit(rx_bit), .rx_valid(rx_valid), .rx_done(rx_done), .rx_err(rx_err),
    .tx_start(tx_start), .tx_len(tx_len), .tx_bit(tx_bit),
    .tx_req(tx_req), .tx_busy(tx_busy), .tx_done(tx_done)
  );

  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic add(input logic [1:0] s, input logic v, input logic b, input logic d, input logic e);
    sym_q.push_back(s); ev_q.push_back(v); eb_q.push_back(b); ed_q.push_back(d); ee_q.push_back(e);
  endtask

  // kind: 0 clean EOP, 1 SE1 after n bits, 2 K symbol after SE0, 3 overflow (128 bits)
  task automatic build_rx(input int brk, input int n, input logic [127:0] bits, input int se0n, input int kind);
    sym_q.delete(); ev_q.delete(); eb_q.delete(); ed_q.delete(); ee_q.delete();
    add(2'b10, 1'b0, 1'b0, 1'b0, 1'b0);
    if (brk > 0) begin
      for (int i = 0; i < brk; i++) add({sync_v[7-i], ~sync_v[7-i]}, 1'b0, 1'b0, 1'b0, 1'b0);
      add({~sync_v[7-brk], sync_v[7-brk]}, 1'b0, 1'b0, 1'b0, 1'b0);
      add(2'b10, 1'b0, 1'b0, 1'b0, 1'b0);
    end
    for (int i = 0; i < 8; i++) add({sync_v[7-i], ~sync_v[7-i]}, 1'b0, 1'b0, 1'b0, 1'b0);
    if (kind == 3) begin
      for (int i = 0; i < 128; i++) add({bits[i], ~bits[i]}, i < 127, bits[i], 1'b0, i == 127);
      add(2'b00, 1'b0, 1'b0, 1'b0, 1'b0);
      add(2'b10, 1'b0, 1'b0, 1'b0, 1'b0);
    end else begin
      for (int i = 0; i < n; i++) add({bits[i], ~bits[i]}, 1'b1, bits[i], 1'b0, 1'b0);
      if (kind == 1) begin
        add(2'b11, 1'b0, 1'b0, 1'b0, 1'b1);
      end else begin
        for (int s = 0; s < se0n; s++) add(2'b00, 1'b0, 1'b0, 1'b0, 1'b0);
        add((kind == 0) ? 2'b10 : 2'b01, 1'b0, 1'b0, kind == 0, kind == 2);
      end
    end
    add(2'b10, 1'b0, 1'b0, 1'b0, 1'b0);
    add(2'b10, 1'b0, 1'b0, 1'b0, 1'b0);
  endtask

  task automatic test_reset();
    rst_b = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    n_cmp++;
    if ({dp_out, dm_out, oe, rx_bit, rx_valid, rx_done, rx_err, tx_req, tx_busy, tx_done} !== 10'b10_0000_0000) begin
      n_bad++;
      $display("FAIL reset_values: got %b want %b",
               {dp_out, dm_out, oe, rx_bit, rx_valid, rx_done, rx_err, tx_req, tx_busy, tx_done}, 10'b10_0000_0000);
    end
    rst_b = 1'b1;
    step();
  endtask

  task automatic test_rx_packets();
    logic [127:0] bits;
    int brk, n, se0n, kind;
    for (int p = 0; p < 40; p++) begin
      bits = {$urandom, $urandom, $urandom, $urandom};
      brk  = ($urandom_range(0, 1) == 1) ? int'($urandom_range(1, 7)) : 0;
      n    = $urandom_range(0, 20);
      se0n = $urandom_range(1, 3);
      kind = $urandom_range(0, 2);
      case (p)
        0: begin brk = 0; n = 4; bits[3:0] = 4'b1101; se0n = 2; kind = 0; end
        1: begin brk = 4; kind = 0; end
        2: begin brk = 0; n = 3; kind = 1; end
        3: begin brk = 0; kind = 3; end
        4: begin brk = 0; n = 127; se0n = 2; kind = 0; end
        default: ;
      endcase
      build_rx(brk, n, bits, se0n, kind);
      for (int k = 0; k < sym_q.size(); k++) begin
        {dp_in, dm_in} = sym_q[k];
        step();
        n_cmp++;
        if (rx_valid !== ev_q[k]) begin
          n_bad++;
          $display("FAIL rx_valid pkt%0d sym%0d: got %b want %b", p, k, rx_valid, ev_q[k]);
        end
        if (ev_q[k]) begin
          n_cmp++;
          if (rx_bit !== eb_q[k]) begin
            n_bad++;
            $display("FAIL rx_bit pkt%0d sym%0d: got %b want %b", p, k, rx_bit, eb_q[k]);
          end
        end
        n_cmp++;
        if ({rx_done, rx_err} !== {ed_q[k], ee_q[k]}) begin
          n_bad++;
          $display("FAIL rx_done_err pkt%0d sym%0d: got %b want %b", p, k, {rx_done, rx_err}, {ed_q[k], ee_q[k]});
        end
      end
    end
  endtask

  task automatic test_tx_packets();
    logic [127:0] bits;
    logic [5:0]   got, want;
    int L, tot, k, d, js;
    logic noise, mid, e_oe, e_dp, e_dm;
    for (int it = 0; it < 20; it++) begin
      bits  = {$urandom, $urandom, $urandom, $urandom};
      L     = $urandom_range(1, 24);
      noise = (it >= 2);
      mid   = (it >= 3);
      if (it == 0) begin L = 5; bits[4:0] = 5'b01011; end
      if (it == 1) L = 0;
      if (it == 2) L = 127;
      tot = TA + 8 + L + SE0N + 1;
      js  = $urandom_range(0, tot - 1);
      {dp_in, dm_in} = 2'b10;
      tx_len   = 7'(L);
      tx_start = 1'b1;
      tx_bit   = 1'($urandom);
      step();
      tx_start = 1'b0;
      for (int j = 0; j <= tot + 1; j++) begin
        k    = j - TA;
        e_oe = (j >= TA) && (j < tot);
        if (!e_oe)                 begin e_dp = 1'b1;           e_dm = 1'b0; end
        else if (k < 8)            begin e_dp = sync_v[7-k];    e_dm = ~e_dp; end
        else if (k < 8 + L)        begin e_dp = bits[k-8];      e_dm = ~e_dp; end
        else if (k < 8 + L + SE0N) begin e_dp = 1'b0;           e_dm = 1'b0; end
        else                       begin e_dp = 1'b1;           e_dm = 1'b0; end
        want = {e_oe, e_dp, e_dm, (j >= TA + 7) && (j < TA + 7 + L), j < tot, j == tot};
        got  = {oe, dp_out, dm_out, tx_req, tx_busy, tx_done};
        n_cmp++;
        if (got !== want) begin
          n_bad++;
          $display("FAIL tx_line len%0d cyc%0d {oe,dp,dm,req,busy,done}: got %b want %b", L, j, got, want);
        end
        n_cmp++;
        if ({rx_valid, rx_done, rx_err} !== 3'b000) begin
          n_bad++;
          $display("FAIL rx_quiet_in_tx len%0d cyc%0d: got %b want 000", L, j, {rx_valid, rx_done, rx_err});
        end
        d        = j - (TA + 7);
        tx_bit   = (d >= 0 && d < L) ? bits[d] : 1'($urandom);
        tx_start = mid && (j == js);
        if (tx_start) tx_len = 7'($urandom);
        {dp_in, dm_in} = (noise && j < tot) ? 2'($urandom) : 2'b10;
        step();
      end
      tx_start = 1'b0;
    end
  endtask

  task automatic test_tx_during_rx();
    {dp_in, dm_in} = 2'b10;
    step();
    for (int i = 0; i < 8; i++) begin
      {dp_in, dm_in} = {sync_v[7-i], ~sync_v[7-i]};
      tx_start = (i == 3);
      tx_len   = 7'd5;
      step();
      tx_start = 1'b0;
      n_cmp++;
      if ({tx_busy, oe} !== 2'b00) begin
        n_bad++;
        $display("FAIL tx_start_in_sync sym%0d {busy,oe}: got %b want 00", i, {tx_busy, oe});
      end
    end
    {dp_in, dm_in} = 2'b01;
    tx_start = 1'b1;
    step();
    tx_start = 1'b0;
    n_cmp++;
    if ({tx_busy, oe, rx_valid, rx_bit} !== 4'b0010) begin
      n_bad++;
      $display("FAIL tx_start_in_data {busy,oe,valid,bit}: got %b want 0010", {tx_busy, oe, rx_valid, rx_bit});
    end
    {dp_in, dm_in} = 2'b00;
    step();
    {dp_in, dm_in} = 2'b10;
    step();
    n_cmp++;
    if ({rx_done, rx_err, tx_busy} !== 3'b100) begin
      n_bad++;
      $display("FAIL rx_after_ignored_tx {done,err,busy}: got %b want 100", {rx_done, rx_err, tx_busy});
    end
    step();
  endtask

  task automatic test_reset_mid_tx();
    {dp_in, dm_in} = 2'b10;
    tx_len   = 7'd10;
    tx_start = 1'b1;
    step();
    tx_start = 1'b0;
    for (int j = 0; j < TA + 8 + 3; j++) begin
      tx_bit = 1'($urandom);
      step();
    end
    n_cmp++;
    if ({oe, tx_busy} !== 2'b11) begin
      n_bad++;
      $display("FAIL pre_reset_in_data {oe,busy}: got %b want 11", {oe, tx_busy});
    end
    #2;
    rst_b = 1'b0;
    #1;
    n_cmp++;
    if ({oe, dp_out, dm_out, tx_req, tx_busy, tx_done, rx_valid, rx_err} !== 8'b0100_0000) begin
      n_bad++;
      $display("FAIL async_reset {oe,dp,dm,req,busy,done,valid,err}: got %b want 01000000",
               {oe, dp_out, dm_out, tx_req, tx_busy, tx_done, rx_valid, rx_err});
    end
    @(posedge clk);
    #1;
    rst_b = 1'b1;
    for (int j = 0; j < 30; j++) begin
      step();
      n_cmp++;
      if ({oe, tx_busy, tx_done, rx_done, rx_err} !== 5'b00000) begin
        n_bad++;
        $display("FAIL after_reset cyc%0d {oe,busy,done,rx_done,rx_err}: got %b want 00000",
                 j, {oe, tx_busy, tx_done, rx_done, rx_err});
      end
    end
  endtask

  initial begin
    test_reset();
    test_rx_packets();
    test_tx_packets();
    test_tx_during_rx();
    test_reset_mid_tx();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
